// File: rtl/alu_seq.sv
// Registered 8-operation ALU with start/busy/done handshake, status flags and a
// tri-state result bus. MUL is an unsigned shift-add taking WIDTH cycles.
module alu_seq #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] reg_a,
   input  logic [WIDTH-1:0] reg_b,
   input  logic             enable_output,
   output tri   [WIDTH-1:0] bus,
   output logic             busy,
   output logic             done,
   output logic             CF,
   output logic             ZF,
   output logic             NF,
   output logic             VF
);

   localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_SHL = 3'b101;
   localparam logic [2:0] OP_SHR = 3'b110;
   localparam logic [2:0] OP_MUL = 3'b111;

   typedef enum logic {S_IDLE, S_MUL} state_t;

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     result_q, result_d;
   logic                 cf_q, cf_d, zf_q, zf_d, nf_q, nf_d, vf_q, vf_d;
   logic                 busy_q, busy_d, done_q, done_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   mcand_q, mcand_d;
   logic [WIDTH-1:0]     mplier_q, mplier_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;

   logic [WIDTH-1:0]     opb;
   logic [WIDTH:0]       sum;
   logic [WIDTH-1:0]     alu_res;
   logic                 alu_cf, alu_vf;
   logic [2*WIDTH-1:0]   acc_step;

   // Two's-complement overflow: operands agree in sign, result disagrees.
   function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
      return (a_msb == b_msb) && (r_msb != a_msb);
   endfunction

   // SUB reuses the adder as A + ~B + 1, so CF=1 means no borrow.
   assign opb      = (op == OP_SUB) ? ~reg_b : reg_b;
   assign sum      = {1'b0, reg_a} + {1'b0, opb} + {{WIDTH{1'b0}}, (op == OP_SUB)};
   assign acc_step = acc_q + (mplier_q[0] ? mcand_q : {(2*WIDTH){1'b0}});

   always_comb begin
      alu_res = sum[WIDTH-1:0];
      alu_cf  = 1'b0;
      alu_vf  = 1'b0;
      case (op)
         OP_ADD, OP_SUB: begin
            alu_res = sum[WIDTH-1:0];
            alu_cf  = sum[WIDTH];
            alu_vf  = add_ovf(reg_a[WIDTH-1], opb[WIDTH-1], sum[WIDTH-1]);
         end
         OP_AND: alu_res = reg_a & reg_b;
         OP_OR:  alu_res = reg_a | reg_b;
         OP_XOR: alu_res = reg_a ^ reg_b;
         OP_SHL: begin
            alu_res = {reg_a[WIDTH-2:0], 1'b0};
            alu_cf  = reg_a[WIDTH-1];
         end
         OP_SHR: begin
            alu_res = {1'b0, reg_a[WIDTH-1:1]};
            alu_cf  = reg_a[0];
         end
         default: alu_res = sum[WIDTH-1:0];
      endcase
   end

   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      cf_d     = cf_q;
      zf_d     = zf_q;
      nf_d     = nf_q;
      vf_d     = vf_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      cnt_d    = cnt_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (op == OP_MUL) begin
                  mcand_d  = {{WIDTH{1'b0}}, reg_a};
                  mplier_d = reg_b;
                  acc_d    = '0;
                  cnt_d    = '0;
                  busy_d   = 1'b1;
                  state_d  = S_MUL;
               end else begin
                  result_d = alu_res;
                  cf_d     = alu_cf;
                  vf_d     = alu_vf;
                  zf_d     = ~|alu_res;
                  nf_d     = alu_res[WIDTH-1];
                  done_d   = 1'b1;
               end
            end
         end
         S_MUL: begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               result_d = acc_step[WIDTH-1:0];
               cf_d     = |acc_step[2*WIDTH-1:WIDTH];
               vf_d     = 1'b0;
               zf_d     = ~|acc_step[WIDTH-1:0];
               nf_d     = acc_step[WIDTH-1];
               busy_d   = 1'b0;
               done_d   = 1'b1;
               cnt_d    = '0;
               state_d  = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         result_q <= '0;
         cf_q     <= 1'b0;
         zf_q     <= 1'b0;
         nf_q     <= 1'b0;
         vf_q     <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         cf_q     <= cf_d;
         zf_q     <= zf_d;
         nf_q     <= nf_d;
         vf_q     <= vf_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         cnt_q    <= cnt_d;
      end
   end

   // Multiplier datapath is fully reloaded at every MUL launch, so no reset.
   always_ff @(posedge clk) begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
   end

   assign bus  = enable_output ? result_q : {WIDTH{1'bz}};
   assign busy = busy_q;
   assign done = done_q;
   assign CF   = cf_q;
   assign ZF   = zf_q;
   assign NF   = nf_q;
   assign VF   = vf_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq at WIDTH=8 and WIDTH=16; the bus nets are pulled
// high so a released bus reads as all ones.
module tb_alu_seq;

   localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3,
                          XOR_ = 3'd4, SHL = 3'd5, SHR = 3'd6, MUL = 3'd7;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        start8 = 1'b0, en8 = 1'b1;
   logic [2:0]  op8 = 3'd0;
   logic [7:0]  a8 = '0, b8 = '0;
   tri1  [7:0]  bus8;
   logic        busy8, done8, cf8, zf8, nf8, vf8;

   logic        start16 = 1'b0, en16 = 1'b1;
   logic [2:0]  op16 = 3'd0;
   logic [15:0] a16 = '0, b16 = '0;
   tri1  [15:0] bus16;
   logic        busy16, done16, cf16, zf16, nf16, vf16;

   alu_seq #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .op(op8), .reg_a(a8), .reg_b(b8),
      .enable_output(en8), .bus(bus8), .busy(busy8), .done(done8),
      .CF(cf8), .ZF(zf8), .NF(nf8), .VF(vf8));

   alu_seq #(.WIDTH(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .start(start16), .op(op16), .reg_a(a16), .reg_b(b16),
      .enable_output(en16), .bus(bus16), .busy(busy16), .done(done16),
      .CF(cf16), .ZF(zf16), .NF(nf16), .VF(vf16));

   int n_checks = 0;
   int n_errors = 0;
   logic [35:0] q8[$];
   logic [35:0] q16[$];

   task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference model: {result, CF, ZF, NF, VF} from plain integer arithmetic.
   function automatic logic [35:0] model(input int w, input logic [2:0] o,
                                         input longint a, input longint b);
      longint mask, half, r, sa, sb, sr;
      logic   cf, vf, zf, nf;
      logic [31:0] rr;
      mask = (64'sd1 <<< w) - 1;
      half = 64'sd1 <<< (w - 1);
      sa   = (a >= half) ? a - (mask + 1) : a;
      sb   = (b >= half) ? b - (mask + 1) : b;
      cf   = 1'b0;
      vf   = 1'b0;
      r    = 0;
      case (o)
         ADD:  begin r = a + b; cf = (r > mask); sr = sa + sb; vf = (sr >= half) || (sr < -half); end
         SUB:  begin r = a - b; cf = (a >= b);   sr = sa - sb; vf = (sr >= half) || (sr < -half); end
         AND_: r = a & b;
         OR_:  r = a | b;
         XOR_: r = a ^ b;
         SHL:  begin r = a << 1; cf = ((a >> (w - 1)) & 1) != 0; end
         SHR:  begin r = a >> 1; cf = (a & 1) != 0; end
         default: begin r = a * b; cf = (r > mask); end
      endcase
      r  = r & mask;
      rr = r[31:0];
      zf = (r == 0);
      nf = ((r >> (w - 1)) & 1) != 0;
      return {rr, cf, zf, nf, vf};
   endfunction

   always @(negedge clk) begin
      if (done8) begin
         if (q8.size() == 0) chk("done8_spurious", {35'b0, done8}, 36'b0);
         else chk("res8", {24'b0, bus8, cf8, zf8, nf8, vf8}, q8.pop_front());
      end
      if (done16) begin
         if (q16.size() == 0) chk("done16_spurious", {35'b0, done16}, 36'b0);
         else chk("res16", {16'b0, bus16, cf16, zf16, nf16, vf16}, q16.pop_front());
      end
   end

   task automatic issue8(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
      @(negedge clk);
      start8 = 1'b1; op8 = o; a8 = a; b8 = b;
      q8.push_back(model(8, o, a, b));
      @(negedge clk);
      start8 = 1'b0;
   endtask

   task automatic issue16(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b);
      @(negedge clk);
      start16 = 1'b1; op16 = o; a16 = a; b16 = b;
      q16.push_back(model(16, o, a, b));
      @(negedge clk);
      start16 = 1'b0;
   endtask

   // Counts the remaining busy cycles (bounded) and checks the total.
   task automatic mul_wait8(input int pre, input string tag);
      int cycles = pre;
      while (busy8 && cycles < 64) begin
         cycles++;
         @(negedge clk);
      end
      chk(tag, 36'(cycles), 36'd8);
   endtask

   task automatic mul_wait16(input int pre, input string tag);
      int cycles = pre;
      while (busy16 && cycles < 64) begin
         cycles++;
         @(negedge clk);
      end
      chk(tag, 36'(cycles), 36'd16);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("reset8_state", {24'b0, bus8, busy8, done8, cf8, zf8, nf8, vf8, 2'b0}, 36'h0);
      chk("reset16_state", {16'b0, bus16, busy16, done16, cf16, zf16, nf16, vf16}, 36'h0);
      rst_n = 1'b1;

      issue8(ADD, 8'hFF, 8'h01);
      chk("t1_done_hi", {34'b0, done8, busy8}, 36'b10);
      @(negedge clk);
      chk("t1_done_lo", {34'b0, done8, busy8}, 36'b00);

      issue8(ADD, 8'h7F, 8'h01);
      issue8(SUB, 8'h50, 8'h70);
      issue8(SUB, 8'h70, 8'h70);
      issue8(SHL, 8'h81, 8'h00);
      issue8(SHR, 8'h81, 8'h00);
      issue8(OR_, 8'h0C, 8'h30);
      issue8(AND_, 8'hF0, 8'h3C);
      issue8(XOR_, 8'hAA, 8'hAA);

      issue8(MUL, 8'h0F, 8'h11);
      mul_wait8(0, "mul_0f_busy_cycles");
      issue8(MUL, 8'h10, 8'h10);
      start8 = 1'b1; op8 = ADD; a8 = 8'h55; b8 = 8'h01;
      @(negedge clk);
      start8 = 1'b0; a8 = 8'hAA;
      mul_wait8(1, "mul_10_busy_cycles");
      @(negedge clk);
      chk("mul_no_extra_done", {35'b0, done8}, 36'b0);

      en8 = 1'b0;
      #1 chk("bus_released", {28'b0, bus8}, 36'hFF);
      chk("flags_hold_en0", {32'b0, cf8, zf8, nf8, vf8}, 36'b1100);
      @(negedge clk);
      en8 = 1'b1;
      #1 chk("bus_driven", {28'b0, bus8}, 36'h00);
      chk("flags_hold_en1", {32'b0, cf8, zf8, nf8, vf8}, 36'b1100);

      issue8(MUL, 8'h0F, 8'h03);
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      q8.delete();
      @(negedge clk);
      chk("mid_mul_reset", {24'b0, bus8, busy8, done8, cf8, zf8, nf8, vf8, 2'b0}, 36'h0);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      chk("abort_no_done", {35'b0, done8}, 36'b0);
      issue8(ADD, 8'h03, 8'h04);

      issue16(ADD, 16'hFFFF, 16'h0001);
      chk("w16_done_hi", {34'b0, done16, busy16}, 36'b10);
      issue16(MUL, 16'h00FF, 16'h0101);
      mul_wait16(0, "w16_mul_busy_cycles");
      issue16(SUB, 16'h1234, 16'h8000);

      repeat (3) @(negedge clk);
      chk("q8_drained", 36'(q8.size()), 36'd0);
      chk("q16_drained", 36'(q16.size()), 36'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
